// File: rtl/multicycle_cpu_top.sv
// Multi-cycle MIPS-subset core: one shared ALU, unified instr/data memory, 32x32 register file.
// Each instruction takes 3-5 edges; no handshake I/O, state is observed through the memory arrays.
module ID_memory #(
  parameter int INSTR_MEM_SIZE = 64,
  parameter int DATA_MEM_SIZE  = 64,
  parameter int ADDR_W         = 7
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] instr_and_data_memory [0:INSTR_MEM_SIZE+DATA_MEM_SIZE-1];

  assign rdata_o = instr_and_data_memory[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) instr_and_data_memory[addr_i] <= wdata_i;
  end
endmodule

module reg_file (
  input  logic        clk_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] mem_reg [0:31];

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : mem_reg[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : mem_reg[ra2_i];

  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != 5'd0)) mem_reg[wa_i] <= wd_i;
  end
endmodule

module multicycle_cpu_top #(
  parameter int INSTR_MEM_SIZE = 64,
  parameter int DATA_MEM_SIZE  = 64
) (
  input logic CLK,
  input logic RSTn
);
  localparam int ADDR_W = $clog2(INSTR_MEM_SIZE + DATA_MEM_SIZE);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, ADDIEXEC, ADDIWB, BRANCH, JUMP
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;

  logic [5:0]  op, funct, alu_fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, alu_a, alu_b, alu_y;
  logic [31:0] fetch_idx, data_idx, mem_rdata, rf_rd1, rf_rd2, rf_wd;
  logic [ADDR_W-1:0] mem_addr;
  logic        mem_we, rf_we, rtype_wr;
  logic [4:0]  rf_wa;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};

  // Instruction fetches wrap inside the instruction region; data accesses wrap inside the data region.
  assign fetch_idx = {2'b00, pc_q[31:2]} % 32'(INSTR_MEM_SIZE);
  assign data_idx  = 32'(INSTR_MEM_SIZE) + ({2'b00, aluout_q[31:2]} % 32'(DATA_MEM_SIZE));
  assign mem_addr  = (state_q == FETCH) ? fetch_idx[ADDR_W-1:0] : data_idx[ADDR_W-1:0];
  assign mem_we    = !RSTn && (state_q == MEMWRITE);

  assign rtype_wr = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                    (funct == 6'h25) || (funct == 6'h2A);
  assign rf_we    = !RSTn && ((state_q == ALUWB && rtype_wr) || state_q == ADDIWB ||
                              state_q == MEMWB);
  assign rf_wa    = (state_q == ALUWB) ? rd : rt;
  assign rf_wd    = (state_q == MEMWB) ? mdr_q : aluout_q;

  logic unused_idx_hi;
  assign unused_idx_hi = ^{fetch_idx[31:ADDR_W], data_idx[31:ADDR_W]};

  always_comb begin
    alu_a  = a_q;
    alu_b  = simm;
    alu_fn = 6'h20;
    case (state_q)
      FETCH:   begin alu_a = pc_q; alu_b = 32'd4; end
      DECODE:  begin alu_a = pc_q; alu_b = {simm[29:0], 2'b00}; end
      EXECUTE: begin alu_b = b_q; alu_fn = funct; end
      default: ;
    endcase
    case (alu_fn)
      6'h22:   alu_y = alu_a - alu_b;
      6'h24:   alu_y = alu_a & alu_b;
      6'h25:   alu_y = alu_a | alu_b;
      6'h2A:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      state_q  <= FETCH;
      pc_q     <= 32'd0;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
      mdr_q    <= 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          ir_q    <= mem_rdata;
          pc_q    <= alu_y;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q      <= rf_rd1;
          b_q      <= rf_rd2;
          aluout_q <= alu_y;
          case (op)
            6'h23, 6'h2B: state_q <= MEMADR;
            6'h00:        state_q <= EXECUTE;
            6'h08:        state_q <= ADDIEXEC;
            6'h04:        state_q <= BRANCH;
            6'h02:        state_q <= JUMP;
            default:      state_q <= FETCH;
          endcase
        end
        MEMADR: begin
          aluout_q <= alu_y;
          state_q  <= (op == 6'h23) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          mdr_q   <= mem_rdata;
          state_q <= MEMWB;
        end
        EXECUTE, ADDIEXEC: begin
          aluout_q <= alu_y;
          state_q  <= (state_q == EXECUTE) ? ALUWB : ADDIWB;
        end
        BRANCH: begin
          if (a_q == b_q) pc_q <= aluout_q;
          state_q <= FETCH;
        end
        JUMP: begin
          pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  ID_memory #(
    .INSTR_MEM_SIZE(INSTR_MEM_SIZE),
    .DATA_MEM_SIZE (DATA_MEM_SIZE),
    .ADDR_W        (ADDR_W)
  ) i_ID_memory (
    .clk_i  (CLK),
    .addr_i (mem_addr),
    .we_i   (mem_we),
    .wdata_i(b_q),
    .rdata_o(mem_rdata)
  );

  reg_file i_reg_file (
    .clk_i(CLK),
    .ra1_i(rs),
    .ra2_i(rt),
    .rd1_o(rf_rd1),
    .rd2_o(rf_rd2),
    .we_i (rf_we),
    .wa_i (rf_wa),
    .wd_i (rf_wd)
  );
endmodule

// File: tb/tb_multicycle_cpu_top.sv
// Directed bench for multicycle_cpu_top: backdoor-loaded programs, results read from the arrays.
module tb_multicycle_cpu_top;
  localparam int IMS = 64;
  localparam int DMS = 64;

  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] prog_main [11] = '{
    32'h20030080, 32'h2004000F, 32'hAC040010, 32'h8C050010, 32'h10A40003, 32'h8C050010,
    32'h10A40003, 32'h00000000, 32'h10640010, 32'h00000000, 32'h08000002};
  logic [31:0] prog_rtype [5] = '{
    32'h00223020, 32'h00223822, 32'h00224024, 32'h00224825, 32'h0022502A};

  multicycle_cpu_top #(.INSTR_MEM_SIZE(IMS), .DATA_MEM_SIZE(DMS)) dut (
    .CLK (CLK),
    .RSTn(RSTn)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < IMS + DMS; i++) dut.i_ID_memory.instr_and_data_memory[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.i_reg_file.mem_reg[i] = 32'd0;
  endtask

  task automatic load_main();
    for (int i = 0; i < 11; i++) dut.i_ID_memory.instr_and_data_memory[i] = prog_main[i];
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RSTn = 1'b0;
  endtask

  initial begin
    // Main program: addi, sw, lw, beq taken, beq not taken, nop, jump loop.
    RSTn = 1'b1;
    clear_all();
    load_main();
    edges(2);
    chk("rst_pc", dut.pc_q, 32'd0);
    chk("rst_ir", dut.ir_q, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    release_reset();
    edges(4);
    chk("addi_r3", dut.i_reg_file.mem_reg[3], 32'd128);
    edges(4);
    chk("addi_r4", dut.i_reg_file.mem_reg[4], 32'd15);
    edges(4);
    chk("sw_mem68", dut.i_ID_memory.instr_and_data_memory[IMS+4], 32'd15);
    chk("instr4_intact", dut.i_ID_memory.instr_and_data_memory[4], 32'h10A40003);
    edges(5);
    chk("lw_r5", dut.i_reg_file.mem_reg[5], 32'd15);
    edges(3);
    chk("beq_taken_pc", dut.pc_q, 32'h20);
    edges(10);
    chk("jump_pc", dut.pc_q, 32'h08);
    edges(22);
    chk("loop_pc", dut.pc_q, 32'h08);
    chk("loop_r3", dut.i_reg_file.mem_reg[3], 32'd128);
    chk("loop_r4", dut.i_reg_file.mem_reg[4], 32'd15);
    chk("loop_r5", dut.i_reg_file.mem_reg[5], 32'd15);
    chk("loop_mem68", dut.i_ID_memory.instr_and_data_memory[IMS+4], 32'd15);

    // R-type ALU operations on $1 = 7, $2 = 9.
    RSTn = 1'b1;
    clear_all();
    for (int i = 0; i < 5; i++) dut.i_ID_memory.instr_and_data_memory[i] = prog_rtype[i];
    dut.i_reg_file.mem_reg[1] = 32'd7;
    dut.i_reg_file.mem_reg[2] = 32'd9;
    release_reset();
    edges(4);
    chk("add_r6", dut.i_reg_file.mem_reg[6], 32'd16);
    edges(4);
    chk("sub_r7", dut.i_reg_file.mem_reg[7], 32'hFFFFFFFE);
    edges(4);
    chk("and_r8", dut.i_reg_file.mem_reg[8], 32'd1);
    edges(4);
    chk("or_r9", dut.i_reg_file.mem_reg[9], 32'd15);
    edges(4);
    chk("slt_r10", dut.i_reg_file.mem_reg[10], 32'd1);
    chk("rtype_pc", dut.pc_q, 32'h14);

    // Reset lands after the MEMADR edge of the sw, before its write edge.
    RSTn = 1'b1;
    clear_all();
    load_main();
    release_reset();
    edges(11);
    RSTn = 1'b1;
    #1;
    chk("abort_pc", dut.pc_q, 32'd0);
    chk("abort_ir", dut.ir_q, 32'd0);
    edges(1);
    chk("abort_mem68", dut.i_ID_memory.instr_and_data_memory[IMS+4], 32'd0);
    chk("abort_r4_kept", dut.i_reg_file.mem_reg[4], 32'd15);
    dut.i_reg_file.mem_reg[3] = 32'd0;
    release_reset();
    edges(4);
    chk("restart_r3", dut.i_reg_file.mem_reg[3], 32'd128);
    chk("restart_pc", dut.pc_q, 32'h04);
    edges(8);
    chk("restart_mem68", dut.i_ID_memory.instr_and_data_memory[IMS+4], 32'd15);

    // Writes to $0 are dropped and $0 keeps reading zero.
    RSTn = 1'b1;
    clear_all();
    dut.i_ID_memory.instr_and_data_memory[0] = 32'h20000005;
    dut.i_ID_memory.instr_and_data_memory[1] = 32'h200B0003;
    release_reset();
    edges(4);
    chk("r0_kept_zero", dut.i_reg_file.mem_reg[0], 32'd0);
    edges(4);
    chk("r0_reads_zero", dut.i_reg_file.mem_reg[11], 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
